// File: rtl/barrel_normalizer.sv
// barrel_normalizer
//   Finds the shift that normalizes a word: moves the leading 1 to the MSB (dir = 0) or the
//   trailing 1 to the LSB (dir = 1), one bit per cycle. Returns the normalized word, the
//   number of 1-bit shifts applied and a flag for an all-zero input.
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   data_in / dir valid
//   in_ready   high only while idle
//   data_in    word to normalize
//   dir        0 = toward MSB, 1 = toward LSB
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   data_out   normalized word
//   shift      number of 1-bit shifts applied
//   zero       data_in was all zeros
module barrel_normalizer #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned SHIFT_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data_in,
   input  logic               dir,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   data_out,
   output logic [SHIFT_W-1:0] shift,
   output logic               zero
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     work_q, work_d;
   logic                 dir_q, dir_d;
   logic [SHIFT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]     data_out_q, data_out_d;
   logic [SHIFT_W-1:0]   shift_q, shift_d;
   logic                 zero_q, zero_d;
   logic                 target;

   // Bit that must be set for the word to count as normalized in the latched direction.
   assign target = dir_q ? work_q[0] : work_q[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         work_q     <= '0;
         dir_q      <= 1'b0;
         count_q    <= '0;
         data_out_q <= '0;
         shift_q    <= '0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         dir_q      <= dir_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         shift_q    <= shift_d;
         zero_q     <= zero_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      dir_d      = dir_q;
      count_d    = count_q;
      data_out_d = data_out_q;
      shift_d    = shift_q;
      zero_d     = zero_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               work_d  = data_in;
               dir_d   = dir;
               count_d = '0;
               if (data_in == '0) begin
                  // Nothing to search for; report zero straight away.
                  state_d    = StDone;
                  zero_d     = 1'b1;
                  shift_d    = '0;
                  data_out_d = '0;
               end else begin
                  state_d = StShift;
                  zero_d  = 1'b0;
               end
            end
         end
         StShift: begin
            if (target) begin
               state_d    = StDone;
               data_out_d = work_q;
               shift_d    = count_q;
            end else begin
               // Non-zero word: target is reached within WIDTH-1 steps, so count cannot wrap.
               work_d  = dir_q ? (work_q >> 1) : (work_q << 1);
               count_d = count_q + SHIFT_W'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign data_out  = data_out_q;
   assign shift     = shift_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_barrel_normalizer.sv
module tb_barrel_normalizer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] data_in = 4'd0;
   logic       dir = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] data_out;
   logic [1:0] shift;
   logic       zero;

   barrel_normalizer #(.WIDTH(4), .SHIFT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .dir       (dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .shift     (shift),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] din;
      logic       d;
      logic [3:0] dout;
      logic [1:0] sh;
      logic       z;
      int         acc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic rnd_en = 1'b0;
   logic hold_ready = 1'b1;
   logic prev_ov = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Single driver of out_ready, changed well away from both clock edges.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready = rnd_en ? ($urandom_range(0, 3) != 0) : hold_ready;
      end
   end

   // Monitor: latency on the rising edge of out_valid, result on each output handshake.
   always @(negedge clk) begin
      if (rst) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (sbq.size() == 0) begin
               chk("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
               // Zero input raises out_valid on the accept edge itself, otherwise k+1 later.
               chk("latency", 32'(cyc - sbq[0].acc),
                   sbq[0].z ? 32'd0 : 32'(sbq[0].sh) + 32'd1);
            end
         end
         if (out_valid && out_ready && sbq.size() > 0) begin
            exp_t e;
            logic [3:0] back;
            e = sbq.pop_front();
            chk("data_out", 32'(data_out), 32'(e.dout));
            chk("shift", 32'(shift), 32'(e.sh));
            chk("zero", 32'(zero), 32'(e.z));
            back = e.d ? (data_out << shift) : (data_out >> shift);
            chk("inverse", 32'(back), 32'(e.din));
         end
         prev_ov = out_valid;
      end
   end

   function automatic void model(input logic [3:0] din, input logic d,
                                 output logic [3:0] o, output logic [1:0] s, output logic z);
      o = din;
      s = 2'd0;
      z = (din == 4'd0);
      if (!z) begin
         while (d ? !o[0] : !o[3]) begin
            o = d ? (o >> 1) : (o << 1);
            s = s + 2'd1;
         end
      end
   endfunction

   task automatic send(input logic [3:0] din, input logic d, input logic [3:0] edout,
                       input logic [1:0] esh, input logic ez, input bit expect_result);
      int   n;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = din;
      dir      = d;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         if (expect_result) begin
            e.din = din; e.d = d; e.dout = edout; e.sh = esh; e.z = ez; e.acc = cyc;
            sbq.push_back(e);
         end
         in_valid = 1'b0;
         // Scramble the inputs; the block must not sample them outside idle.
         data_in  = 4'($urandom);
         dir      = 1'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((sbq.size() != 0 || !in_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0 || !in_ready) chk("idle_timeout", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      logic [3:0] mo;
      logic [1:0] ms;
      logic       mz;
      int         n;

      // Power-on reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_shift", 32'(shift), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors: din, dir, expected data_out, shift, zero
      send(4'b0010, 1'b0, 4'b1000, 2'd2, 1'b0, 1'b1); wait_idle();
      send(4'b1000, 1'b1, 4'b0001, 2'd3, 1'b0, 1'b1); wait_idle();
      send(4'b1010, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b1); wait_idle();
      send(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1); wait_idle();
      send(4'b0001, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b1); wait_idle();
      send(4'b0110, 1'b1, 4'b0011, 2'd1, 1'b0, 1'b1); wait_idle();
      send(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b1); wait_idle();
      send(4'b0101, 1'b1, 4'b0101, 2'd0, 1'b0, 1'b1); wait_idle();

      // Backpressure: result held for 5 cycles, new input ignored meanwhile
      hold_ready = 1'b0;
      repeat (2) @(negedge clk);
      send(4'b0100, 1'b0, 4'b1000, 2'd1, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      data_in  = 4'b0001;
      dir      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_data_out", 32'(data_out), 32'b1000);
         chk("bp_shift", 32'(shift), 32'd1);
         chk("bp_zero", 32'(zero), 32'd0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid   = 1'b0;
      hold_ready = 1'b1;
      n = 0;
      while (!(out_valid && out_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      repeat (6) @(negedge clk);
      chk("bp_no_extra", 32'(sbq.size()), 32'd0);

      // Reset mid-SHIFT aborts the word
      send(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_data_out", 32'(data_out), 32'd0);
      chk("abort_shift", 32'(shift), 32'd0);
      chk("abort_zero", 32'(zero), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      repeat (8) @(negedge clk);
      chk("abort_in_ready_later", 32'(in_ready), 32'd1);

      // Random words with random direction and output stalls
      rnd_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [3:0] din;
         logic       d;
         din = 4'($urandom);
         d   = 1'($urandom);
         model(din, d, mo, ms, mz);
         send(din, d, mo, ms, mz, 1'b1);
      end
      wait_idle();
      rnd_en = 1'b0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
